// File: rtl/hilo_pkg.sv
// Shared types and constants for the execute-stage HI/LO divide sequencer.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    localparam int MF_READ = 1;
    localparam int MF_HI   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract divisor.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quot_n
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit: the shifted remainder can exceed WIDTH bits.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            rem_n  = diff[WIDTH-1:0];
            quot_n = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_n  = shifted[WIDTH-1:0];
            quot_n = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_div_sequencer.sv
// HI/LO unit beside the E-stage ALU: multi-cycle div/divu plus mfhi/mflo reads.
module hilo_div_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       mf_sel,
    output logic [WIDTH-1:0] hl_out,
    output logic             busy,
    output logic             stall,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_nx, quot_nx;

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .rem    (rem_q),
        .quot   (quot_q),
        .dvsr   (dvsr_q),
        .rem_n  (rem_nx),
        .quot_n (quot_nx)
    );

    always_comb begin
        a_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quot_d  = a_mag;
                    dvsr_d  = b_mag;
                    qsign_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rsign_d = signed_op & dividend[WIDTH-1];
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = qsign_q ? -quot_q : quot_q;
                hi_d    = rsign_q ? -rem_q : rem_q;
                dz_d    = (dvsr_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Only a dependent mf or a second div in E has to wait.
    always_comb begin
        busy     = (state_q != IDLE);
        stall    = busy & (start | mf_sel[MF_READ]);
        hl_out   = mf_sel[MF_HI] ? hi_q : lo_q;
        div_zero = dz_q;
    end

endmodule

// File: doc/hilo_div_sequencer.md
# hilo_div_sequencer

Multi-cycle sequencer for the execute-stage HI/LO unit: accepts a divide request from the E stage, runs a 32-iteration restoring division, writes HI (remainder) and LO (quotient), and serves mfhi/mflo reads. Sits beside the ALU in E. Its `stall` output is ORed into the hazard unit's StallF/StallD and E-hold, so the pipeline freezes while a result is pending and a dependent mf or second div is in E.

## Interface
- `WIDTH`, 32: operand/result width; iteration count equals WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  divE: divide instruction present in E this cycle.
- `signed_op`  in  1  1 = div (signed), 0 = divu.
- `dividend`  in  WIDTH  SrcAE.
- `divisor`  in  WIDTH  SrcBE.
- `mf_sel`  in  2  mfE: bit1 = read request, bit0 = 1 HI / 0 LO.
- `hl_out`  out  WIDTH  selected HI or LO (combinational from registers).
- `busy`  out  1  division in progress.
- `stall`  out  1  freeze F/D/E this cycle.
- `div_zero`  out  1  sticky flag, last accepted divide had divisor 0.

## Operation
- Reset: state IDLE, HI=0, LO=0, iteration counter=0, busy=0, stall=0, div_zero=0, hl_out=0.
- States: IDLE, RUN, FIX.
- IDLE: `start`=1 → latch |dividend|, |divisor| (magnitudes when signed_op, raw otherwise), latch sign of quotient (dividend[31]^divisor[31]) and remainder (dividend[31]), both 0 for divu; clear partial remainder; counter=0; → RUN. Start accepted in IDLE does not stall; the div instruction proceeds to M.
- RUN: per cycle shift {rem,quot} left 1, trial-subtract divisor from rem; non-negative → keep difference, quotient bit 1; else restore, bit 0. Counter increments; after iteration WIDTH-1 → FIX.
- FIX: negate quotient/remainder per latched signs (two's complement, WIDTH bits, wrap); write LO=quotient, HI=remainder; → IDLE.
- Divisor 0: iterations still run; result by construction LO=all ones (0xFFFFFFFF before sign fix), HI=|dividend|, sign fix applied; div_zero set in FIX, cleared at next accepted start.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0 (natural wrap, no flag).
- stall = (state≠IDLE) & (start | mf_sel[1]). Non-dependent instructions flow while busy.
- hl_out = mf_sel[0] ? HI : LO, regardless of mf_sel[1].
- start and mf_sel[1] both set in IDLE: start accepted, hl_out shows pre-divide value.
- start held high through a stall is a new, independent request; accepted on the first IDLE cycle.
- Reset mid-operation: abort, all state to reset values; no partial HI/LO write.

## Timing
- Start sampled at edge 0 in IDLE; RUN occupies edges 1..WIDTH; FIX writes HI/LO at edge WIDTH+1. State returns to IDLE at edge WIDTH+1, so a read in the following cycle sees the new value: WIDTH+2 cycles start-to-readable (34 for WIDTH=32).
- busy=1 from cycle after start through FIX cycle inclusive.
- stall combinational from state and inputs; no register delay.
- HI/LO only change on FIX edge or reset.

## Structure
- Package `hilo_pkg`: state enum (IDLE/RUN/FIX), MF_READ/MF_HI bit-index constants, WIDTH default.
- Sub-module `div_iter`: one restoring step (rem, quot, divisor → next rem, next quot), purely combinational; sequencer owns all registers, counter and sign fix.

## Test plan
- divu 100/7 at start, mf_sel=10 held from next cycle → stall high 33 cycles, then LO=14; mf_sel=11 → HI=2.
- div −7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); div 7/−2 → LO=−3, HI=1.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, div_zero=0.
- divu 5/0 → LO=0xFFFFFFFF, HI=5, div_zero=1; next divu 6/3 clears flag, LO=2.
- Back-to-back: second start during RUN → stall=1 until IDLE, then accepted, results of both correct in order; unrelated instruction (start=0, mf_sel=00) during RUN → stall=0.
- rst_n low at iteration 10 → HI=LO=0, busy=0 immediately; subsequent divu 9/3 → LO=3, HI=0.
